// File: rtl/ocl_aes_block_packer_if.sv
// OCL write strobe + AES block handshake + status bundle for ocl_aes_block_packer.
// slave = packer side, master = OCL/AES/read-mux side.
interface ocl_aes_block_packer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_valid;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic          blk_valid;
  logic [127:0]  blk_data;
  logic          blk_ready;
  logic [CW-1:0] fifo_count;
  logic [1:0]    word_idx;
  logic          overflow;

  modport slave (
    input  wr_valid, wr_addr, wr_data, blk_ready,
    output blk_valid, blk_data, fifo_count, word_idx, overflow
  );

  modport master (
    output wr_valid, wr_addr, wr_data, blk_ready,
    input  blk_valid, blk_data, fifo_count, word_idx, overflow
  );
endinterface

// File: rtl/ocl_aes_block_packer.sv
// Packs four 32-bit OCL data writes into a 128-bit block and queues it for the AES core.
// Optional OCL_AES_PACK_BYTE_SWAP_EN byte-reverses each incoming word before storage.
module ocl_aes_block_packer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] DATA_ADDR = 32'h0000_0510,
  parameter logic [31:0] CTRL_ADDR = 32'h0000_0514
) (
  input  logic                   clk_main_a0,
  input  logic                   rst_main,
  ocl_aes_block_packer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [127:0]  mem_q [DEPTH];
  logic [31:0]   asm_q [3];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    widx_q, widx_d;
  logic          ovf_q, ovf_d;

  logic          data_wr, ctrl_wr, flush, clr_ovf;
  logic          pop, commit, push, drop;
  logic [31:0]   word_in;
  logic [127:0]  blk_new;

`ifdef OCL_AES_PACK_BYTE_SWAP_EN
  assign word_in = {bus.wr_data[7:0], bus.wr_data[15:8], bus.wr_data[23:16], bus.wr_data[31:24]};
`else
  assign word_in = bus.wr_data;
`endif

  assign data_wr = bus.wr_valid && (bus.wr_addr == DATA_ADDR);
  assign ctrl_wr = bus.wr_valid && (bus.wr_addr == CTRL_ADDR);
  assign flush   = ctrl_wr && bus.wr_data[0];
  assign clr_ovf = ctrl_wr && bus.wr_data[1];

  // Full + pop in the same cycle still accepts: the slot being vacated is the one written.
  assign pop     = (cnt_q != '0) && bus.blk_ready;
  assign commit  = data_wr && (widx_q == 2'd3);
  assign push    = commit && ((cnt_q < FULL) || pop);
  assign drop    = commit && !push;
  assign blk_new = {asm_q[0], asm_q[1], asm_q[2], word_in};

  always_comb begin
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    widx_d = widx_q;
    ovf_d  = ovf_q;
    if (flush) begin
      rd_d   = '0;
      wr_d   = '0;
      cnt_d  = '0;
      widx_d = '0;
    end else begin
      if (data_wr) widx_d = widx_q + 2'd1;
      if (push)    wr_d   = wr_q + 1'b1;
      if (pop)     rd_d   = rd_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
      if (drop)    ovf_d  = 1'b1;
    end
    if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_main_a0) begin
    if (rst_main) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      for (int i = 0; i < 3; i++)     asm_q[i] <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      widx_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (data_wr) begin
        case (widx_q)
          2'd0:    asm_q[0] <= word_in;
          2'd1:    asm_q[1] <= word_in;
          2'd2:    asm_q[2] <= word_in;
          default: ;
        endcase
      end
      if (push) mem_q[wr_q] <= blk_new;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      widx_q <= widx_d;
      ovf_q  <= ovf_d;
    end
  end

  // Head is read from registered storage, so blk_ready never reaches the outputs combinationally.
  assign bus.blk_valid  = (cnt_q != '0);
  assign bus.blk_data   = mem_q[rd_q];
  assign bus.fifo_count = cnt_q;
  assign bus.word_idx   = widx_q;
  assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_ocl_aes_block_packer.sv
// Scoreboard bench for ocl_aes_block_packer: directed writes push expected blocks, a monitor checks pops.
module tb_ocl_aes_block_packer;
  localparam logic [31:0] DA = 32'h0000_0510;
  localparam logic [31:0] CA = 32'h0000_0514;
  localparam logic [31:0] XA = 32'h0000_0500;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ocl_aes_block_packer_if #(.DEPTH(4)) bus ();

  ocl_aes_block_packer #(.DEPTH(4), .DATA_ADDR(DA), .CTRL_ADDR(CA)) dut (
    .clk_main_a0 (clk),
    .rst_main    (rst),
    .bus         (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q [$];
  bit stream_chk = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef OCL_AES_PACK_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] mkw(input int b, input int i);
    return {8'(b), 8'(i), 16'h1234 + 16'(b * 7 + i)};
  endfunction

  // Monitor: every handshake pops the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.blk_valid && bus.blk_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block: got %h expected none", bus.blk_data);
      end else begin
        chk("blk_data", bus.blk_data, exp_q.pop_front());
      end
    end
    if (!rst && stream_chk) chk("stream_count_le1", 128'(bus.fifo_count > 3'd1), 128'd0);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    step(1);
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
  endtask

  // Writes four words of block b; 'emerge' says whether it should later leave the FIFO.
  task automatic blk(input int b, input bit emerge);
    for (int i = 0; i < 4; i++) wr(DA, mkw(b, i));
    if (emerge) exp_q.push_back({sw(mkw(b, 0)), sw(mkw(b, 1)), sw(mkw(b, 2)), sw(mkw(b, 3))});
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.blk_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    step(1);
    bus.blk_ready = 1'b0;
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 128'(bus.blk_valid), 128'd0);
    chk({tag, "_count"}, 128'(bus.fifo_count), 128'd0);
    chk({tag, "_widx"},  128'(bus.word_idx), 128'd0);
    chk({tag, "_ovf"},   128'(bus.overflow), 128'd0);
    chk({tag, "_data"},  bus.blk_data, 128'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.blk_ready = 1'b0;
    step(2);
    rst = 1'b0;
    chk_reset("reset");

    // Basic assembly and latency
    wr(DA, 32'h00112233);
    chk("widx_after_1", 128'(bus.word_idx), 128'd1);
    wr(DA, 32'h44556677);
    wr(DA, 32'h8899AABB);
    wr(DA, 32'hCCDDEEFF);
    chk("basic_valid", 128'(bus.blk_valid), 128'd1);
    chk("basic_count", 128'(bus.fifo_count), 128'd1);
`ifdef OCL_AES_PACK_BYTE_SWAP_EN
    chk("basic_data", bus.blk_data, 128'h33221100_77665544_BBAA9988_FFEEDDCC);
    exp_q.push_back(128'h33221100_77665544_BBAA9988_FFEEDDCC);
`else
    chk("basic_data", bus.blk_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    exp_q.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
`endif
    drain();

    // Overflow: fifth block dropped
    for (int b = 1; b <= 4; b++) blk(b, 1'b1);
    chk("full_ovf_pre", 128'(bus.overflow), 128'd0);
    blk(5, 1'b0);
    chk("full_count", 128'(bus.fifo_count), 128'd4);
    chk("full_ovf", 128'(bus.overflow), 128'd1);
    chk("full_widx", 128'(bus.word_idx), 128'd0);
    drain();
    chk("drained_valid", 128'(bus.blk_valid), 128'd0);
    chk("ovf_sticky", 128'(bus.overflow), 128'd1);
    wr(CA, 32'h2);
    chk("ovf_clear", 128'(bus.overflow), 128'd0);

    // Full with coincident pop: block accepted and queued last
    for (int b = 10; b <= 13; b++) blk(b, 1'b1);
    for (int i = 0; i < 3; i++) wr(DA, mkw(14, i));
    bus.blk_ready = 1'b1;
    wr(DA, mkw(14, 3));
    bus.blk_ready = 1'b0;
    exp_q.push_back({sw(mkw(14, 0)), sw(mkw(14, 1)), sw(mkw(14, 2)), sw(mkw(14, 3))});
    chk("popfull_count", 128'(bus.fifo_count), 128'd4);
    chk("popfull_ovf", 128'(bus.overflow), 128'd0);
    drain();

    // Flush mid-assembly with queued blocks
    blk(20, 1'b0);
    blk(21, 1'b0);
    wr(DA, mkw(22, 0));
    wr(DA, mkw(22, 1));
    chk("preflush_widx", 128'(bus.word_idx), 128'd2);
    chk("preflush_count", 128'(bus.fifo_count), 128'd2);
    wr(CA, 32'h1);
    chk("flush_count", 128'(bus.fifo_count), 128'd0);
    chk("flush_widx", 128'(bus.word_idx), 128'd0);
    chk("flush_valid", 128'(bus.blk_valid), 128'd0);
    blk(23, 1'b1);
    chk("postflush_head", bus.blk_data,
        {sw(mkw(23, 0)), sw(mkw(23, 1)), sw(mkw(23, 2)), sw(mkw(23, 3))});
    drain();

    // Streaming with pointer wrap and ignored address writes
    bus.blk_ready = 1'b1;
    stream_chk = 1'b1;
    for (int b = 30; b < 42; b++) begin
      wr(DA, mkw(b, 0));
      wr(XA, 32'hFFFF_FFFF);
      wr(DA, mkw(b, 1));
      wr(DA, mkw(b, 2));
      wr(XA, 32'h0000_0003);
      wr(DA, mkw(b, 3));
      exp_q.push_back({sw(mkw(b, 0)), sw(mkw(b, 1)), sw(mkw(b, 2)), sw(mkw(b, 3))});
    end
    drain();
    stream_chk = 1'b0;
    chk("stream_count", 128'(bus.fifo_count), 128'd0);
    chk("stream_ovf", 128'(bus.overflow), 128'd0);

    // Reset mid-assembly with a queued block
    blk(50, 1'b0);
    for (int i = 0; i < 3; i++) wr(DA, mkw(51, i));
    chk("prerst_count", 128'(bus.fifo_count), 128'd1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk_reset("midrst");

    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
